// File: rtl/trdb_pkg.sv
// Shared types for the trace encoder sequencing controller.
package trdb_pkg;

    localparam int TRDB_RESYNC_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_START,
        ST_WAIT_FIRST,
        ST_RUN,
        ST_LOST,
        ST_STOP
    } trdb_ctrl_state_e;

endpackage

// File: rtl/trdb_resync_cnt.sv
// Resync timer: saturating counter plus sticky pending flag; clear beats
// every other input.
module trdb_resync_cnt #(
    parameter int          RESYNC_W   = 16,
    parameter int unsigned RESYNC_MAX = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_i,
    input  logic                clear_i,
    input  logic                force_pending_i,
    output logic [RESYNC_W-1:0] cnt_o,
    output logic                pending_o
);

    localparam logic [RESYNC_W-1:0] MAX = RESYNC_W'(RESYNC_MAX);
    localparam logic [RESYNC_W-1:0] ONE = RESYNC_W'(1);

    logic [RESYNC_W-1:0] r_cnt;
    logic                r_pending;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            if (inc_i && r_cnt != MAX)
                r_cnt <= r_cnt + ONE;
            // Pending latches on the increment that lands on MAX.
            if (force_pending_i || (inc_i && r_cnt == MAX - ONE))
                r_pending <= 1'b1;
        end
    end

    assign cnt_o     = r_cnt;
    assign pending_o = r_pending;

endmodule

// File: rtl/trdb_encoder_ctrl.sv
// Encoder on/off sequencing and support-packet requests.
// TRDB_RESYNC_PKT_CNT_EN: resync timer counts emitted packets, not cycles.
module trdb_encoder_ctrl
    import trdb_pkg::*;
#(
    parameter int          RESYNC_W   = TRDB_RESYNC_W_DEFAULT,
    parameter int unsigned RESYNC_MAX = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                trace_enable_i,
    input  logic                qualified_i,
    input  logic                retired_i,
    input  logic                lost_i,
    input  logic                sync_pkt_done_i,
    input  logic                pkt_emitted_i,
    input  logic                supp_ready_i,
    output logic                supp_valid_o,
    output logic                enc_enabled_o,
    output logic                enc_disabled_o,
    output logic                final_instr_traced_o,
    output logic                packets_lost_o,
    output logic                first_qualified_o,
    output logic                exception_sync_o,
    output logic                encoder_active_o,
    output logic [RESYNC_W-1:0] resync_cnt_o
);

    trdb_ctrl_state_e r_state;
    logic             r_lost_flag;
    logic             r_final_flag;

    logic w_supp_valid, w_hs, w_first, w_active, w_start_entry, w_inc;

    assign w_supp_valid  = (r_state == ST_START) || (r_state == ST_LOST) || (r_state == ST_STOP);
    assign w_hs          = w_supp_valid && supp_ready_i;
    assign w_first       = (r_state == ST_WAIT_FIRST) && trace_enable_i && qualified_i && retired_i;
    assign w_active      = (r_state == ST_RUN) || (r_state == ST_LOST);
    assign w_start_entry = (r_state == ST_OFF) && trace_enable_i;

`ifdef TRDB_RESYNC_PKT_CNT_EN
    assign w_inc = w_active && pkt_emitted_i;
`else
    logic w_unused_pkt;
    assign w_unused_pkt = pkt_emitted_i;
    assign w_inc        = w_active;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_OFF;
            r_lost_flag  <= 1'b0;
            r_final_flag <= 1'b0;
        end else begin
            // A loss reported on the handshake cycle belongs to the next report.
            if (r_state != ST_OFF && lost_i)
                r_lost_flag <= 1'b1;
            else if (w_hs)
                r_lost_flag <= 1'b0;

            case (r_state)
                ST_OFF: if (trace_enable_i) r_state <= ST_START;
                ST_START:
                    if (supp_ready_i) begin
                        if (trace_enable_i) begin
                            r_state <= ST_WAIT_FIRST;
                        end else begin
                            r_state      <= ST_STOP;
                            r_final_flag <= 1'b0;
                        end
                    end
                ST_WAIT_FIRST:
                    if (!trace_enable_i) begin
                        r_state      <= ST_STOP;
                        r_final_flag <= 1'b0;
                    end else if (w_first) begin
                        r_state <= ST_RUN;
                    end
                ST_RUN:
                    if (!trace_enable_i) begin
                        r_state      <= ST_STOP;
                        r_final_flag <= 1'b1;
                    end else if (r_lost_flag) begin
                        r_state <= ST_LOST;
                    end else if (!qualified_i) begin
                        r_state <= ST_WAIT_FIRST;
                    end
                ST_LOST: if (supp_ready_i) r_state <= ST_RUN;
                ST_STOP:
                    if (supp_ready_i) begin
                        r_state      <= ST_OFF;
                        r_final_flag <= 1'b0;
                    end
                default: r_state <= ST_OFF;
            endcase
        end
    end

    trdb_resync_cnt #(
        .RESYNC_W   (RESYNC_W),
        .RESYNC_MAX (RESYNC_MAX)
    ) u_resync (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .inc_i           (w_inc),
        .clear_i         (sync_pkt_done_i || w_start_entry),
        .force_pending_i (lost_i && (r_state != ST_OFF)),
        .cnt_o           (resync_cnt_o),
        .pending_o       (exception_sync_o)
    );

    assign supp_valid_o         = w_supp_valid;
    assign enc_enabled_o        = (r_state == ST_START);
    assign enc_disabled_o       = (r_state == ST_STOP);
    assign final_instr_traced_o = (r_state == ST_STOP) && r_final_flag;
    assign packets_lost_o       = (r_state == ST_LOST) || (w_supp_valid && r_lost_flag);
    assign first_qualified_o    = w_first;
    assign encoder_active_o     = (r_state == ST_WAIT_FIRST) || w_active;

endmodule
